// File: rtl/ttt_auto_opponent.sv
// Purpose: automatic second player for the tic-tac-toe core; forwards human moves, replies as player 1.
// Latency: human accept -> human update 1 cycle; human update -> auto update 3 cycles; auto update -> ready 2 cycles.
// Backpressure: human_ready is high only while waiting for a human move; moves are taken on valid && ready.
module ttt_auto_opponent (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       human_valid,
    input  logic [1:0] human_row,
    input  logic [1:0] human_col,
    output logic       human_ready,
    output logic       illegal,
    output logic       game_rst,
    output logic       player,
    output logic       update,
    output logic [1:0] row,
    output logic [1:0] col,
    input  logic       gameOver,
    input  logic       winner,
    input  logic       draw,
    input  logic       ERR,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic       fault
);

    typedef enum logic [3:0] {
        IDLE, CLEAR, WAIT_H, ISSUE_H, CHK_H, THINK, ISSUE_A, CHK_A, DONE
    } state_t;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_HUMAN = 2'b01;
    localparam logic [1:0] CELL_AUTO  = 2'b10;

    // Cell triples of the 8 lines: rows, columns, diagonals, in priority order.
    localparam logic [3:0] LINES [24] = '{
        4'd0, 4'd1, 4'd2,  4'd3, 4'd4, 4'd5,  4'd6, 4'd7, 4'd8,
        4'd0, 4'd3, 4'd6,  4'd1, 4'd4, 4'd7,  4'd2, 4'd5, 4'd8,
        4'd0, 4'd4, 4'd8,  4'd2, 4'd4, 4'd6
    };

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [1:0]  row_q, row_d, col_q, col_d;
    logic [1:0]  result_q, result_d;
    logic        player_q, player_d;
    logic        fault_q, fault_d;
    logic        illegal_q, illegal_d;
    logic        game_rst_q, game_rst_d;
    logic        human_ready_q, human_ready_d;
    logic        update_q, update_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  pick_idx;
    logic [1:0]  pick_row, pick_col;
    logic [3:0]  human_idx;
    logic [3:0]  move_idx;
    logic        human_bad;

    // Out-of-range indices read as empty so callers need no extra guard.
    function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] idx);
        logic [1:0] v;
        v = CELL_EMPTY;
        for (int i = 0; i < 9; i++) begin
            if (idx == 4'(i)) v = b[i*2 +: 2];
        end
        return v;
    endfunction

    // Returns {found, empty cell} for the first line holding two of 'who' and one empty.
    function automatic logic [4:0] find_line(input logic [17:0] b, input logic [1:0] who);
        logic [4:0] res;
        logic [1:0] cv;
        logic [3:0] eidx;
        logic       efound;
        int         cnt;
        res = 5'd0;
        for (int l = 0; l < 8; l++) begin
            cnt    = 0;
            efound = 1'b0;
            eidx   = 4'd0;
            for (int k = 0; k < 3; k++) begin
                cv = cell_of(b, LINES[l*3 + k]);
                if (cv == who) begin
                    cnt = cnt + 1;
                end else if (cv == CELL_EMPTY) begin
                    efound = 1'b1;
                    eidx   = LINES[l*3 + k];
                end
            end
            if (!res[4] && cnt == 2 && efound) res = {1'b1, eidx};
        end
        return res;
    endfunction

    // Auto move choice: win, block, centre, corners, edges.
    always_comb begin
        logic [4:0] win_l;
        logic [4:0] blk_l;
        win_l    = find_line(board_q, CELL_AUTO);
        blk_l    = find_line(board_q, CELL_HUMAN);
        pick_idx = 4'd0;
        if (win_l[4])                           pick_idx = win_l[3:0];
        else if (blk_l[4])                      pick_idx = blk_l[3:0];
        else if (board_q[9:8]   == CELL_EMPTY)  pick_idx = 4'd4;
        else if (board_q[1:0]   == CELL_EMPTY)  pick_idx = 4'd0;
        else if (board_q[5:4]   == CELL_EMPTY)  pick_idx = 4'd2;
        else if (board_q[13:12] == CELL_EMPTY)  pick_idx = 4'd6;
        else if (board_q[17:16] == CELL_EMPTY)  pick_idx = 4'd8;
        else if (board_q[3:2]   == CELL_EMPTY)  pick_idx = 4'd1;
        else if (board_q[7:6]   == CELL_EMPTY)  pick_idx = 4'd3;
        else if (board_q[11:10] == CELL_EMPTY)  pick_idx = 4'd5;
        else if (board_q[15:14] == CELL_EMPTY)  pick_idx = 4'd7;
        pick_row = 2'd0;
        pick_col = 2'd0;
        case (pick_idx)
            4'd0: begin pick_row = 2'd0; pick_col = 2'd0; end
            4'd1: begin pick_row = 2'd0; pick_col = 2'd1; end
            4'd2: begin pick_row = 2'd0; pick_col = 2'd2; end
            4'd3: begin pick_row = 2'd1; pick_col = 2'd0; end
            4'd4: begin pick_row = 2'd1; pick_col = 2'd1; end
            4'd5: begin pick_row = 2'd1; pick_col = 2'd2; end
            4'd6: begin pick_row = 2'd2; pick_col = 2'd0; end
            4'd7: begin pick_row = 2'd2; pick_col = 2'd1; end
            4'd8: begin pick_row = 2'd2; pick_col = 2'd2; end
            default: begin pick_row = 2'd0; pick_col = 2'd0; end
        endcase
    end

    // Local legality check of the presented human move and index of the latched move.
    always_comb begin
        human_idx = ({2'b00, human_row} * 4'd3) + {2'b00, human_col};
        move_idx  = ({2'b00, row_q} * 4'd3) + {2'b00, col_q};
        human_bad = (human_row == 2'd3) || (human_col == 2'd3) ||
                    (cell_of(board_q, human_idx) != CELL_EMPTY);
    end

    // Next state, board update and registered-output values derived from the next state.
    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        row_d     = row_q;
        col_d     = col_q;
        player_d  = player_q;
        result_d  = result_q;
        fault_d   = fault_q;
        illegal_d = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = WAIT_H;
            WAIT_H: begin
                if (human_valid) begin
                    if (human_bad) begin
                        illegal_d = 1'b1;
                    end else begin
                        row_d    = human_row;
                        col_d    = human_col;
                        player_d = 1'b0;
                        state_d  = ISSUE_H;
                    end
                end
            end
            ISSUE_H: state_d = CHK_H;
            CHK_H: begin
                if (ERR) begin
                    illegal_d = 1'b1;
                    state_d   = WAIT_H;
                end else begin
                    for (int i = 0; i < 9; i++) begin
                        if (move_idx == 4'(i)) board_d[i*2 +: 2] = CELL_HUMAN;
                    end
                    if (gameOver) begin
                        result_d = winner ? 2'd1 : (draw ? 2'd3 : 2'd0);
                        state_d  = DONE;
                    end else begin
                        state_d = THINK;
                    end
                end
            end
            THINK: begin
                row_d    = pick_row;
                col_d    = pick_col;
                player_d = 1'b1;
                state_d  = ISSUE_A;
            end
            ISSUE_A: state_d = CHK_A;
            CHK_A: begin
                if (ERR) begin
                    fault_d  = 1'b1;
                    result_d = 2'd0;
                    state_d  = DONE;
                end else begin
                    for (int i = 0; i < 9; i++) begin
                        if (move_idx == 4'(i)) board_d[i*2 +: 2] = CELL_AUTO;
                    end
                    if (gameOver) begin
                        result_d = winner ? 2'd2 : (draw ? 2'd3 : 2'd0);
                        state_d  = DONE;
                    end else begin
                        state_d = WAIT_H;
                    end
                end
            end
            DONE:    if (start) state_d = CLEAR;
            default: state_d = IDLE;
        endcase
        // Entering CLEAR wipes the previous game so it never shows during the new one.
        if (state_d == CLEAR) begin
            board_d  = 18'd0;
            result_d = 2'd0;
            fault_d  = 1'b0;
        end
        game_rst_d    = (state_d == CLEAR);
        human_ready_d = (state_d == WAIT_H);
        update_d      = (state_d == ISSUE_H) || (state_d == ISSUE_A);
        busy_d        = (state_d != IDLE) && (state_d != DONE);
        done_d        = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            board_q       <= 18'd0;
            row_q         <= 2'd0;
            col_q         <= 2'd0;
            player_q      <= 1'b0;
            result_q      <= 2'd0;
            fault_q       <= 1'b0;
            illegal_q     <= 1'b0;
            game_rst_q    <= 1'b0;
            human_ready_q <= 1'b0;
            update_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            row_q         <= row_d;
            col_q         <= col_d;
            player_q      <= player_d;
            result_q      <= result_d;
            fault_q       <= fault_d;
            illegal_q     <= illegal_d;
            game_rst_q    <= game_rst_d;
            human_ready_q <= human_ready_d;
            update_q      <= update_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign human_ready = human_ready_q;
    assign illegal     = illegal_q;
    assign game_rst    = game_rst_q;
    assign player      = player_q;
    assign update      = update_q;
    assign row         = row_q;
    assign col         = col_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_ttt_auto_opponent.sv
// Bench for ttt_auto_opponent: a small game-core model answers every update, a scoreboard checks issued moves.
// Latency: checks are sampled on the falling edge, half a cycle after the DUT registers change.
// Backpressure: human moves are presented only while human_ready is high.
module tb_ttt_auto_opponent;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       human_valid = 1'b0;
    logic [1:0] human_row = 2'd0;
    logic [1:0] human_col = 2'd0;
    logic       human_ready, illegal, game_rst, player, update;
    logic [1:0] row, col, result;
    logic       gameOver = 1'b0, winner = 1'b0, draw = 1'b0, ERR = 1'b0;
    logic       busy, done, fault;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_h = 0;
    int pend_cyc = -1;
    bit inj_err = 1'b0;
    int mb [9];
    logic [4:0] exp_q [$];

    ttt_auto_opponent dut (
        .clk(clk), .rst(rst), .start(start),
        .human_valid(human_valid), .human_row(human_row), .human_col(human_col),
        .human_ready(human_ready), .illegal(illegal), .game_rst(game_rst),
        .player(player), .update(update), .row(row), .col(col),
        .gameOver(gameOver), .winner(winner), .draw(draw), .ERR(ERR),
        .busy(busy), .done(done), .result(result), .fault(fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit has_win(input int p);
        return (mb[0]==p && mb[1]==p && mb[2]==p) || (mb[3]==p && mb[4]==p && mb[5]==p) ||
               (mb[6]==p && mb[7]==p && mb[8]==p) || (mb[0]==p && mb[3]==p && mb[6]==p) ||
               (mb[1]==p && mb[4]==p && mb[7]==p) || (mb[2]==p && mb[5]==p && mb[8]==p) ||
               (mb[0]==p && mb[4]==p && mb[8]==p) || (mb[2]==p && mb[4]==p && mb[6]==p);
    endfunction

    // Game-core model: applies each update and presents flags through the following check cycle.
    always @(negedge clk) begin
        int  idx;
        int  p;
        bit  w;
        bit  full;
        if (game_rst) begin
            for (int i = 0; i < 9; i++) mb[i] = 0;
            gameOver = 1'b0; winner = 1'b0; draw = 1'b0; ERR = 1'b0;
        end else if (update) begin
            idx = int'(row) * 3 + int'(col);
            p   = player ? 2 : 1;
            if ((player && inj_err) || mb[idx] != 0) begin
                ERR = 1'b1; gameOver = 1'b0; winner = 1'b0; draw = 1'b0;
            end else begin
                mb[idx] = p;
                w    = has_win(p);
                full = 1'b1;
                for (int i = 0; i < 9; i++) if (mb[i] == 0) full = 1'b0;
                ERR = 1'b0; winner = w; draw = full && !w; gameOver = w || full;
            end
        end
    end

    // Scoreboard and latency monitor for issued moves.
    always @(negedge clk) begin
        logic [4:0] e;
        if (pend_cyc == cyc) begin
            chk("ready_or_done_2cyc_after_auto", {31'd0, human_ready | done}, 32'd1);
            pend_cyc = -1;
        end
        if (update) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_update", {27'd0, player, row, col}, 32'h1f);
            end else begin
                e = exp_q.pop_front();
                chk("move_player_row_col", {27'd0, player, row, col}, {27'd0, e});
                if (player) begin
                    chk("human_to_auto_latency", cyc - last_h, 32'd3);
                    pend_cyc = cyc + 2;
                end else begin
                    last_h = cyc;
                end
            end
        end
    end

    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("game_rst_in_clear", {31'd0, game_rst}, 32'd1);
        chk("result_cleared", {30'd0, result}, 32'd0);
        chk("fault_cleared", {31'd0, fault}, 32'd0);
        chk("busy_in_clear", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("game_rst_one_cycle", {31'd0, game_rst}, 32'd0);
        chk("ready_after_clear", {31'd0, human_ready}, 32'd1);
    endtask

    task automatic wait_ready_or_done(input string name);
        int n;
        n = 0;
        while (!(human_ready || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk(name, 32'd0, 32'd1);
    endtask

    typedef struct {
        bit         new_game;
        logic [1:0] hr, hc;
        bit         ill;
        bit         auto_mv;
        logic [1:0] ar, ac;
        bit         err;
        bit         dn;
        logic [1:0] res;
        bit         flt;
    } vec_t;

    vec_t vt [16];

    initial begin
        // game 1: centre, block, auto win on the 2-4-6 diagonal
        vt[0]  = '{1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[1]  = '{1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[2]  = '{1'b0, 2'd2, 2'd2, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0};
        // game 2: illegal moves, corner choice, row block, human win
        vt[3]  = '{1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[4]  = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[5]  = '{1'b0, 2'd1, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[6]  = '{1'b0, 2'd1, 2'd3, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[7]  = '{1'b0, 2'd2, 2'd2, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[8]  = '{1'b0, 2'd2, 2'd0, 1'b0, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[9]  = '{1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0};
        // game 3: full board, draw on the last human move
        vt[10] = '{1'b1, 2'd1, 2'd1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[11] = '{1'b0, 2'd2, 2'd2, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[12] = '{1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[13] = '{1'b0, 2'd1, 2'd0, 1'b0, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0};
        vt[14] = '{1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd3, 1'b0};
        // game 4: core rejects the auto move
        vt[15] = '{1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 2'd0, 1'b1};

        for (int i = 0; i < 9; i++) mb[i] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", {20'd0, human_ready, illegal, game_rst, player, update,
                              row, col, busy, done, result, fault}, 32'd0);
        @(negedge clk);

        for (int v = 0; v < 16; v++) begin
            if (vt[v].new_game) start_game();
            inj_err = vt[v].err;
            wait_ready_or_done("timeout_wait_ready");
            human_row   = vt[v].hr;
            human_col   = vt[v].hc;
            human_valid = 1'b1;
            if (!vt[v].ill) exp_q.push_back({1'b0, vt[v].hr, vt[v].hc});
            if (vt[v].auto_mv) exp_q.push_back({1'b1, vt[v].ar, vt[v].ac});
            @(negedge clk);
            human_valid = 1'b0;
            chk($sformatf("illegal_v%0d", v), {31'd0, illegal}, {31'd0, vt[v].ill});
            chk($sformatf("ready_after_move_v%0d", v), {31'd0, human_ready}, {31'd0, vt[v].ill});
            if (!vt[v].ill) begin
                @(negedge clk);
                wait_ready_or_done("timeout_settle");
            end
            chk($sformatf("done_v%0d", v), {31'd0, done}, {31'd0, vt[v].dn});
            chk($sformatf("busy_v%0d", v), {31'd0, busy}, {31'd0, !vt[v].dn});
            chk($sformatf("result_v%0d", v), {30'd0, result}, {30'd0, vt[v].res});
            chk($sformatf("fault_v%0d", v), {31'd0, fault}, {31'd0, vt[v].flt});
            chk($sformatf("sb_empty_v%0d", v), exp_q.size(), 32'd0);
            inj_err = 1'b0;
        end

        // start while busy is ignored
        start_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy_no_game_rst", {31'd0, game_rst}, 32'd0);
        chk("start_busy_still_ready", {31'd0, human_ready}, 32'd1);

        // reset during THINK: no auto update, everything back to reset values
        human_row = 2'd0; human_col = 2'd0; human_valid = 1'b1;
        exp_q.push_back({1'b0, 2'd0, 2'd0});
        @(negedge clk);
        human_valid = 1'b0;
        chk("issue_h_update", {31'd0, update}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("think_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_mid_game", {20'd0, human_ready, illegal, game_rst, player, update,
                               row, col, busy, done, result, fault}, 32'd0);
        @(negedge clk);
        chk("idle_after_reset", {30'd0, busy, update}, 32'd0);

        // start and rst together: reset wins
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_beats_start", {29'd0, game_rst, busy, human_ready}, 32'd0);
        @(negedge clk);
        chk("rst_beats_start_idle", {30'd0, busy, game_rst}, 32'd0);
        chk("sb_final_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
